// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one-entry holding buffer feeding an IDLE/LOAD/SEND/DONE
// sequencer that drives an external shift-register/counter datapath.
module uart_tx_ctrl #(
    parameter int BAUD_LAST  = 7,
    parameter int FRAME_BITS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic [7:0] data_in,
    output logic       load_shift_reg,
    output logic       shift_en,
    output logic       mux_sel,
    output logic       clear_baud_counter,
    output logic       clear_bit_counter,
    input  logic [2:0] baud_counter,
    input  logic [3:0] bit_counter,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    localparam logic [2:0] BAUD_END = 3'(BAUD_LAST);
    localparam logic [3:0] BITS     = 4'(FRAME_BITS);

    state_t     state_q, state_d;
    logic       full_q, full_d;
    logic [7:0] buf_q, buf_d;
    logic       err_q, err_d;
    logic       accept, baud_end, overrun;

    // Reset gates the handshake combinationally so nothing is accepted in a reset cycle.
    assign tx_ready = !full_q && !reset;
    assign accept   = tx_valid && tx_ready;
    assign baud_end = (baud_counter == BAUD_END);
    assign overrun  = (state_q == SEND) && (bit_counter > BITS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            full_q  <= 1'b0;
            buf_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    // LOAD only happens with full_q set, so accept and drain never collide.
    always_comb begin
        buf_d  = accept ? tx_byte : buf_q;
        full_d = accept ? 1'b1 : ((state_q == LOAD) ? 1'b0 : full_q);
        err_d  = err_q | overrun;
    end

    always_comb begin
        state_d            = state_q;
        load_shift_reg     = 1'b0;
        shift_en           = 1'b0;
        mux_sel            = 1'b1;
        clear_baud_counter = 1'b1;
        clear_bit_counter  = 1'b1;
        frame_done         = 1'b0;
        data_in            = 8'h00;
        case (state_q)
            IDLE: begin
                if (full_q || accept) state_d = LOAD;
            end
            LOAD: begin
                load_shift_reg = 1'b1;
                data_in        = buf_q;
                state_d        = SEND;
            end
            SEND: begin
                mux_sel            = 1'b0;
                clear_baud_counter = 1'b0;
                clear_bit_counter  = 1'b0;
                shift_en           = baud_end;
                if (overrun || (baud_end && bit_counter >= BITS)) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = (full_q || accept) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset wins mid-frame: outputs go to the idle-line pattern in the same cycle.
        if (reset) begin
            state_d            = IDLE;
            load_shift_reg     = 1'b0;
            shift_en           = 1'b0;
            mux_sel            = 1'b1;
            clear_baud_counter = 1'b1;
            clear_bit_counter  = 1'b1;
            frame_done         = 1'b0;
            data_in            = 8'h00;
        end
    end

    assign busy      = (state_q != IDLE) && !reset;
    assign frame_err = err_q && !reset;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a small behavioural baud/bit counter datapath.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_ready;
    logic [7:0] data_in;
    logic       load_shift_reg, shift_en, mux_sel, clear_baud_counter, clear_bit_counter;
    logic [2:0] baud_counter;
    logic [3:0] bit_counter;
    logic       busy, frame_done, frame_err;

    logic [2:0] baud_q;
    logic [3:0] bit_q;
    logic       force_ovr = 1'b0;

    int total = 0;
    int bad   = 0;

    uart_tx_ctrl #(.BAUD_LAST(7), .FRAME_BITS(10)) dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_byte(tx_byte),
        .tx_ready(tx_ready), .data_in(data_in), .load_shift_reg(load_shift_reg),
        .shift_en(shift_en), .mux_sel(mux_sel), .clear_baud_counter(clear_baud_counter),
        .clear_bit_counter(clear_bit_counter), .baud_counter(baud_counter),
        .bit_counter(bit_counter), .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Datapath model: baud wraps 0..7; bit_counter counts bit periods started (bumps after baud==0).
    always @(posedge clk) begin
        if (clear_baud_counter) baud_q <= 3'd0;
        else                    baud_q <= (baud_q == 3'd7) ? 3'd0 : baud_q + 3'd1;
        if (clear_bit_counter)  bit_q <= 4'd0;
        else if (baud_q == 3'd0) bit_q <= bit_q + 4'd1;
    end
    assign baud_counter = baud_q;
    assign bit_counter  = force_ovr ? 4'd11 : bit_q;

    task step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task test_reset;
        reset = 1'b1; tx_valid = 1'b1; tx_byte = 8'hFF;
        step; step;
        total++;
        if ({tx_ready, mux_sel, clear_baud_counter, clear_bit_counter, load_shift_reg,
             shift_en, frame_done, busy, frame_err} !== 9'b0_1_1_1_0_0_0_0_0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", {tx_ready, mux_sel, clear_baud_counter,
                     clear_bit_counter, load_shift_reg, shift_en, frame_done, busy, frame_err}, 9'b011100000);
        end
        total++;
        if (data_in !== 8'h00) begin bad++; $display("FAIL reset_data_in got=%h exp=00", data_in); end
        reset = 1'b0; tx_valid = 1'b0;
        step;
        total++;
        if ({tx_ready, busy} !== 2'b10) begin
            bad++; $display("FAIL reset_release got ready/busy=%b exp=10", {tx_ready, busy});
        end
    endtask

    task test_idle;
        for (int i = 0; i < 200; i++) begin
            step;
            total++;
            if ({mux_sel, shift_en, busy} !== 3'b100) begin
                bad++; $display("FAIL idle_line cyc=%0d got=%b exp=100", i, {mux_sel, shift_en, busy});
            end
        end
    endtask

    task test_single;
        int   shifts;
        logic exp_shift, exp_done;
        shifts = 0;
        tx_byte = 8'hA5; tx_valid = 1'b1;
        step;
        tx_valid = 1'b0;
        total++;
        if ({load_shift_reg, data_in, tx_ready, busy} !== {1'b1, 8'hA5, 1'b0, 1'b1}) begin
            bad++; $display("FAIL single_load got load=%b data=%h ready=%b busy=%b exp 1 a5 0 1",
                            load_shift_reg, data_in, tx_ready, busy);
        end
        for (int k = 2; k <= 83; k++) begin
            step;
            exp_shift = (k >= 2) && (k <= 81) && (((k - 2) % 8) == 7);
            exp_done  = (k == 82);
            if (shift_en === 1'b1) shifts++;
            total++;
            if ({shift_en, frame_done} !== {exp_shift, exp_done}) begin
                bad++; $display("FAIL single_timing k=%0d got shift/done=%b exp=%b",
                                k, {shift_en, frame_done}, {exp_shift, exp_done});
            end
            if (k == 2) begin
                total++;
                if (mux_sel !== 1'b0) begin bad++; $display("FAIL single_mux_send got=%b exp=0", mux_sel); end
            end
            if (k == 83) begin
                total++;
                if ({busy, mux_sel} !== 2'b01) begin
                    bad++; $display("FAIL single_idle got busy/mux=%b exp=01", {busy, mux_sel});
                end
            end
        end
        total++;
        if (shifts != 10) begin bad++; $display("FAIL single_shift_count got=%0d exp=10", shifts); end
    endtask

    task test_back_to_back;
        logic exp_ready, exp_load, exp_done;
        tx_byte = 8'h55; tx_valid = 1'b1;
        step;
        total++;
        if ({load_shift_reg, data_in} !== {1'b1, 8'h55}) begin
            bad++; $display("FAIL b2b_load1 got load=%b data=%h exp 1 55", load_shift_reg, data_in);
        end
        tx_byte = 8'h0F;
        for (int k = 1; k <= 165; k++) begin
            step;
            exp_ready = (k == 1) || (k >= 83);
            exp_load  = (k == 82);
            exp_done  = (k == 81) || (k == 163);
            total++;
            if ({tx_ready, load_shift_reg, frame_done} !== {exp_ready, exp_load, exp_done}) begin
                bad++; $display("FAIL b2b_seq k=%0d got ready/load/done=%b exp=%b",
                                k, {tx_ready, load_shift_reg, frame_done}, {exp_ready, exp_load, exp_done});
            end
            if (k == 82) begin
                total++;
                if (data_in !== 8'h0F) begin bad++; $display("FAIL b2b_data2 got=%h exp=0f", data_in); end
            end
            if (k == 2) tx_valid = 1'b0;
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b exp=0", busy); end
    endtask

    task test_backpressure;
        logic       exp_ready, exp_load;
        logic [7:0] exp_data;
        tx_byte = 8'h33; tx_valid = 1'b1;
        step;
        total++;
        if ({load_shift_reg, data_in} !== {1'b1, 8'h33}) begin
            bad++; $display("FAIL bp_load0 got load=%b data=%h exp 1 33", load_shift_reg, data_in);
        end
        tx_byte = 8'h11;
        for (int k = 1; k <= 247; k++) begin
            step;
            exp_ready = (k == 1) || (k == 83) || (k >= 165);
            exp_load  = (k == 82) || (k == 164);
            exp_data  = (k == 82) ? 8'h11 : ((k == 164) ? 8'h22 : 8'h00);
            total++;
            if ({tx_ready, load_shift_reg, data_in} !== {exp_ready, exp_load, exp_data}) begin
                bad++; $display("FAIL bp_seq k=%0d got ready=%b load=%b data=%h exp %b %b %h",
                                k, tx_ready, load_shift_reg, data_in, exp_ready, exp_load, exp_data);
            end
            if (k == 2)  tx_byte = 8'h22;
            if (k == 84) tx_valid = 1'b0;
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got busy=%b exp=0", busy); end
    endtask

    task test_overrun;
        tx_byte = 8'h5A; tx_valid = 1'b1;
        step;
        tx_valid = 1'b0;
        repeat (20) step;
        total++;
        if ({busy, frame_err} !== 2'b10) begin
            bad++; $display("FAIL ovr_pre got busy/err=%b exp=10", {busy, frame_err});
        end
        force_ovr = 1'b1;
        step;
        force_ovr = 1'b0;
        total++;
        if ({frame_err, frame_done} !== 2'b11) begin
            bad++; $display("FAIL ovr_flag got err/done=%b exp=11", {frame_err, frame_done});
        end
        step;
        total++;
        if ({busy, frame_err} !== 2'b01) begin
            bad++; $display("FAIL ovr_after got busy/err=%b exp=01", {busy, frame_err});
        end
        repeat (30) step;
        total++;
        if (frame_err !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", frame_err); end
        reset = 1'b1;
        step;
        reset = 1'b0;
        step;
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", frame_err); end
    endtask

    task test_mid_reset;
        logic seen_done;
        tx_byte = 8'hC3; tx_valid = 1'b1;
        step;
        tx_valid = 1'b0;
        repeat (41) step;
        total++;
        if ({busy, mux_sel} !== 2'b10) begin
            bad++; $display("FAIL mrst_send got busy/mux=%b exp=10", {busy, mux_sel});
        end
        reset = 1'b1; tx_valid = 1'b1; tx_byte = 8'h77;
        #1;
        total++;
        if ({tx_ready, mux_sel, frame_done} !== 3'b010) begin
            bad++; $display("FAIL mrst_same got ready/mux/done=%b exp=010", {tx_ready, mux_sel, frame_done});
        end
        step;
        total++;
        if ({busy, mux_sel, tx_ready, frame_done} !== 4'b0100) begin
            bad++; $display("FAIL mrst_next got busy/mux/ready/done=%b exp=0100",
                            {busy, mux_sel, tx_ready, frame_done});
        end
        reset = 1'b0; tx_valid = 1'b0;
        step;
        total++;
        if ({tx_ready, busy} !== 2'b10) begin
            bad++; $display("FAIL mrst_release got ready/busy=%b exp=10", {tx_ready, busy});
        end
        seen_done = 1'b0;
        repeat (100) begin
            step;
            if (frame_done !== 1'b0) seen_done = 1'b1;
        end
        total++;
        if ({seen_done, busy} !== 2'b00) begin
            bad++; $display("FAIL mrst_no_done got seen_done/busy=%b exp=00", {seen_done, busy});
        end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_overrun;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter BAUD_LAST, default 7: baud_counter value that ends one bit period (8 clocks per bit).
REQ-002 SHALL have parameter FRAME_BITS, default 10: bits per frame (start, 8 data, stop).
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_valid  in  1  requester offers a byte.
REQ-006 SHALL have port tx_byte  in  8  byte offered with tx_valid.
REQ-007 SHALL have port tx_ready  out  1  holding buffer empty; byte is accepted when tx_valid && tx_ready.
REQ-008 SHALL have port data_in  out  8  byte presented to the datapath, valid while load_shift_reg=1.
REQ-009 SHALL have ports load_shift_reg, shift_en, mux_sel, clear_baud_counter, clear_bit_counter  out  1 each  datapath controls.
REQ-010 SHALL have port baud_counter  in  3  datapath baud count.
REQ-011 SHALL have port bit_counter  in  4  datapath bit count.
REQ-012 SHALL have port busy  out  1  high in LOAD, SEND or DONE.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse at end of each frame.
REQ-014 SHALL have port frame_err  out  1  sticky overrun flag.

Function
REQ-015 SHALL have a one-entry holding buffer (byte + full flag); tx_ready = !full; an accepted byte sets full.
REQ-016 SHALL have FSM states IDLE, LOAD, SEND, DONE.
REQ-017 IDLE: mux_sel=1, both clears=1, load/shift=0; next state is LOAD when full=1.
REQ-018 LOAD (exactly 1 cycle): load_shift_reg=1, data_in=buffer byte, both clears=1, mux_sel=1; buffer full cleared; next state SEND.
REQ-019 SEND: mux_sel=0, clears=0; shift_en=1 only in cycles with baud_counter==BAUD_LAST.
REQ-020 SEND exits to DONE when baud_counter==BAUD_LAST and bit_counter>=FRAME_BITS; shift_en still pulses in that cycle.
REQ-021 SEND: if bit_counter>FRAME_BITS at any cycle, frame_err SHALL set and the FSM SHALL go to DONE next cycle.
REQ-022 DONE (1 cycle): frame_done=1, mux_sel=1, both clears=1; next state LOAD if full=1, else IDLE.
REQ-023 A frame SHALL occupy 1 LOAD + FRAME_BITS*(BAUD_LAST+1) SEND + 1 DONE cycles (82 at defaults).
REQ-024 Buffer SHALL accept a new byte during SEND/DONE, so a following frame starts with no idle cycle between DONE and LOAD.
REQ-025 Accept and drain SHALL never coincide: the buffer is full in LOAD, so tx_ready=0 that cycle.
REQ-026 tx_byte SHALL be ignored when tx_ready=0; a held tx_valid SHALL NOT corrupt the buffered byte.
REQ-027 busy SHALL equal (state != IDLE); data_in SHALL be 0 outside LOAD.

Reset
REQ-028 reset SHALL take priority over all other events, including mid-frame and mid-handshake.
REQ-029 In reset cycles: state=IDLE, full=0, frame_err=0, tx_ready=0, mux_sel=1, both clears=1, load_shift_reg=0, shift_en=0, frame_done=0, busy=0, data_in=0.
REQ-030 tx_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset during SEND SHALL abandon the frame with no frame_done pulse; the line is idle (mux_sel=1) from the next cycle.

Verification
REQ-032 Single byte: tx_byte=8'hA5 accepted at cycle t -> LOAD at t+1 with data_in=8'hA5; 10 shift_en pulses spaced 8 cycles; frame_done at t+82; then IDLE.
REQ-033 Back-to-back: 8'h55 then 8'h0F offered as soon as tx_ready -> second LOAD immediately follows first DONE; tx_ready=0 only while buffer full.
REQ-034 Backpressure: tx_valid held with 8'h11, then 8'h22, while full -> only 8'h11 transmitted until buffer drains.
REQ-035 Overrun: model forces bit_counter=11 in SEND -> frame_err=1 next cycle, DONE follows, flag stays set until reset.
REQ-036 Mid-frame reset: reset at SEND cycle 40 -> next cycle IDLE, mux_sel=1, tx_ready=0; after release tx_ready=1, no frame_done seen.
REQ-037 Idle line: no tx_valid for 200 cycles after reset -> mux_sel=1, shift_en=0, busy=0 throughout.
